// File: rtl/limn2600_mem_ctrl_if.sv
// Bus bundle for the limn2600 memory controller:
// core request/response channel plus the SRAM port.
interface limn2600_mem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_cs;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rdy;
    logic [31:0] mem_rdata;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata,
        input  mem_cs, mem_we, mem_addr, mem_wdata,
        output mem_rdy, mem_rdata
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata,
        output mem_cs, mem_we, mem_addr, mem_wdata,
        input  mem_rdy, mem_rdata
    );
endinterface

// File: rtl/limn2600_mem_ctrl.sv
// limn2600 CPU-side memory controller: sized loads/stores onto a
// word-wide SRAM, read-modify-write for sub-word stores, with timeout.
module limn2600_mem_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input logic                clk,
    input logic                rst,
    limn2600_mem_ctrl_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, RD, RD_WAIT, WR, WR_WAIT, DONE
    } state_t;

    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;

    logic                  r_we, we_n;
    logic [1:0]            r_size, size_n;
    logic                  r_sgn, sgn_n;
    logic [1:0]            r_lane, lane_n;
    logic [DATA_WIDTH-1:0] r_wdata, wdata_n;

    logic                  req_ready_q;
    logic                  rsp_valid_q;
    logic                  rsp_err_q, err_n;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rdata_n;
    logic                  mem_cs_q;
    logic                  mem_we_q;
    logic [31:0]           mem_addr_q, addr_n;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mwdata_n;

    function automatic logic misaligned(input logic [1:0] size,
                                        input logic [1:0] a);
        return (size == 2'b11) ||
               (size == 2'b01 && a[0]) ||
               (size == 2'b10 && a != 2'b00);
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] w,
                                            input logic [1:0]  size,
                                            input logic [1:0]  lane,
                                            input logic        sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> {lane, 3'b000});
        h = 16'(w >> {lane[1], 4'b0000});
        case (size)
            2'b00:   extract = sgn ? {{24{b[7]}}, b} : {24'h0, b};
            2'b01:   extract = sgn ? {{16{h[15]}}, h} : {16'h0, h};
            default: extract = w;
        endcase
    endfunction

    // Replace only the addressed lane(s) of the word read back from SRAM.
    function automatic logic [31:0] merge(input logic [31:0] w,
                                          input logic [31:0] d,
                                          input logic [1:0]  size,
                                          input logic [1:0]  lane);
        logic [31:0] m;
        logic [31:0] s;
        if (size == 2'b00) begin
            m = 32'h0000_00FF << {lane, 3'b000};
            s = d << {lane, 3'b000};
        end else begin
            m = 32'h0000_FFFF << {lane[1], 4'b0000};
            s = d << {lane[1], 4'b0000};
        end
        return (w & ~m) | (s & m);
    endfunction

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        we_n     = r_we;
        size_n   = r_size;
        sgn_n    = r_sgn;
        lane_n   = r_lane;
        wdata_n  = r_wdata;
        err_n    = 1'b0;
        rdata_n  = '0;
        addr_n   = mem_addr_q;
        mwdata_n = mem_wdata_q;
        unique case (state)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    we_n    = bus.req_we;
                    size_n  = bus.req_size;
                    sgn_n   = bus.req_signed;
                    lane_n  = bus.req_addr[1:0];
                    wdata_n = bus.req_wdata;
                    if (misaligned(bus.req_size, bus.req_addr[1:0])) begin
                        state_n = DONE;
                        err_n   = 1'b1;
                    end else begin
                        addr_n = {bus.req_addr[31:2], 2'b00};
                        if (bus.req_we && bus.req_size == 2'b10) begin
                            state_n  = WR;
                            mwdata_n = bus.req_wdata;
                        end else begin
                            state_n = RD;
                        end
                    end
                end
            end
            RD: begin
                state_n = RD_WAIT;
                cnt_n   = '0;
            end
            WR: begin
                state_n = WR_WAIT;
                cnt_n   = '0;
            end
            RD_WAIT: begin
                if (bus.mem_rdy) begin
                    if (r_we) begin
                        state_n  = WR;
                        mwdata_n = merge(bus.mem_rdata, r_wdata,
                                         r_size, r_lane);
                    end else begin
                        state_n = DONE;
                        rdata_n = extract(bus.mem_rdata, r_size,
                                          r_lane, r_sgn);
                    end
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    state_n = DONE;
                    err_n   = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            WR_WAIT: begin
                if (bus.mem_rdy) begin
                    state_n = DONE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    state_n = DONE;
                    err_n   = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            r_we        <= 1'b0;
            r_size      <= 2'b00;
            r_sgn       <= 1'b0;
            r_lane      <= 2'b00;
            r_wdata     <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            mem_cs_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            r_we        <= we_n;
            r_size      <= size_n;
            r_sgn       <= sgn_n;
            r_lane      <= lane_n;
            r_wdata     <= wdata_n;
            req_ready_q <= (state_n == IDLE);
            rsp_valid_q <= (state_n == DONE);
            rsp_err_q   <= err_n;
            rsp_rdata_q <= rdata_n;
            mem_cs_q    <= (state_n == RD) || (state_n == WR);
            mem_we_q    <= (state_n == WR);
            mem_addr_q  <= addr_n;
            mem_wdata_q <= mwdata_n;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.mem_cs    = mem_cs_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_limn2600_mem_ctrl.sv
// Scoreboard bench for limn2600_mem_ctrl: byte-level reference model,
// SRAM model with optional dead ready line, decoupled negedge monitor.
module tb_limn2600_mem_ctrl;
    localparam int TO = 16;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          ncs;
        logic [1:0]  cs_we;
        logic [31:0] wword;
        logic [31:0] maddr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    limn2600_mem_ctrl_if bus ();

    limn2600_mem_ctrl #(.DATA_WIDTH(32), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    exp_t exp_q[$];
    exp_t cur;
    bit   active = 0;
    bit   mon_en = 0;
    bit   rdy_chk = 0;
    bit   rdy_en = 1;
    bit   preload = 1;
    int   ncyc = 0;
    int   acc = 0;
    int   ncs = 0;
    int   cs_total = 0;
    int   rsp_total = 0;
    logic [31:0] ref_mem [64];
    logic [31:0] ram [64];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bail(input string what);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired (t=%0t)", what, $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    endtask

    // SRAM: answers one cycle after chip select unless its ready line is dead
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) ram[i] <= 32'(i);
        end
        if (rst) begin
            bus.mem_rdy <= 1'b0;
        end else begin
            bus.mem_rdy <= bus.mem_cs && rdy_en;
            if (bus.mem_cs && rdy_en) begin
                bus.mem_rdata <= ram[bus.mem_addr[7:2]];
                if (bus.mem_we) ram[bus.mem_addr[7:2]] <= bus.mem_wdata;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus.mem_cs) cs_total++;
        if (!rst && bus.rsp_valid) rsp_total++;
    end

    task automatic model(input logic we, input logic [1:0] size,
                         input logic sgn, input logic [31:0] addr,
                         input logic [31:0] wd, input bit rdy,
                         output exp_t e);
        int idx, lane, nb;
        logic [7:0] by [4];
        logic [31:0] w, v;
        idx  = int'(addr[7:2]);
        lane = int'(addr[1:0]);
        e.err = 1'b0; e.rdata = 0; e.wword = 0; e.cs_we = 2'b00;
        e.maddr = {addr[31:2], 2'b00};
        e.lat = 3; e.ncs = 1;
        if (size == 2'b11 || (size == 2'b01 && lane % 2 != 0) ||
            (size == 2'b10 && lane != 0)) begin
            e.err = 1'b1; e.lat = 1; e.ncs = 0;
        end else begin
            nb = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
            w = ref_mem[idx];
            for (int k = 0; k < 4; k++) by[k] = w[8*k +: 8];
            if (!we) begin
                v = 0;
                for (int k = 0; k < nb; k++) v = v | (32'(by[lane+k]) << (8*k));
                if (sgn && nb < 4 && by[lane+nb-1][7]) v = v | (32'hFFFF_FFFF << (8*nb));
                e.rdata = v;
            end else begin
                for (int k = 0; k < nb; k++) by[lane+k] = wd[8*k +: 8];
                e.wword = {by[3], by[2], by[1], by[0]};
                if (nb == 4) e.cs_we = 2'b01;
                else begin e.cs_we = 2'b10; e.ncs = 2; e.lat = 5; end
                if (rdy) ref_mem[idx] = e.wword;
            end
            if (!rdy) begin
                e.err = 1'b1; e.rdata = 0; e.ncs = 1; e.lat = TO + 2;
            end
        end
    endtask

    always @(negedge clk) begin
        ncyc++;
        if (mon_en && !rst) begin
            if (rdy_chk) begin
                chk("ready_after_rsp", 32'(bus.req_ready), 32'd1);
                rdy_chk = 0;
            end
            if (bus.req_valid && bus.req_ready) begin
                if (active || exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL accept: unexpected accept (t=%0t)", $time);
                end else begin
                    cur = exp_q.pop_front();
                    active = 1; acc = ncyc; ncs = 0;
                end
            end
            if (bus.mem_cs) begin
                if (!active || ncs >= cur.ncs) begin
                    n_cmp++; n_bad++;
                    $display("FAIL stray_cs: got cs=1 want 0 (t=%0t)", $time);
                end else begin
                    chk("cs_cycle", 32'(ncyc - acc), (ncs == 0) ? 32'd1 : 32'd3);
                    chk("mem_addr", bus.mem_addr, cur.maddr);
                    chk("mem_we", 32'(bus.mem_we), 32'(cur.cs_we[ncs]));
                    if (cur.cs_we[ncs]) chk("mem_wdata", bus.mem_wdata, cur.wword);
                    ncs++;
                end
            end
            if (bus.rsp_valid) begin
                if (!active) begin
                    n_cmp++; n_bad++;
                    $display("FAIL stray_rsp: got rsp_valid=1 want 0 (t=%0t)", $time);
                end else begin
                    chk("rsp_err", 32'(bus.rsp_err), 32'(cur.err));
                    chk("rsp_rdata", bus.rsp_rdata, cur.rdata);
                    chk("latency", 32'(ncyc - acc), 32'(cur.lat));
                    chk("cs_count", 32'(ncs), 32'(cur.ncs));
                    active = 0;
                    rdy_chk = 1;
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [1:0] size,
                         input logic sgn, input logic [31:0] addr,
                         input logic [31:0] wd, input bit rdy);
        exp_t e;
        int k;
        k = 0;
        while (!bus.req_ready) begin
            @(posedge clk); #1;
            k++;
            if (k > 50) bail("req_ready_wait");
        end
        rdy_en = rdy;
        model(we, size, sgn, addr, wd, rdy, e);
        exp_q.push_back(e);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
        bus.req_signed = sgn; bus.req_addr = addr; bus.req_wdata = wd;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        k = 0;
        while (exp_q.size() != 0 || active) begin
            @(posedge clk); #1;
            k++;
            if (k > 60) bail("response_wait");
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
        chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'd0);
        chk({tag, "_mem_cs"}, 32'(bus.mem_cs), 32'd0);
        chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    endtask

    initial begin
        int cs0, rs0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
        bus.req_signed = 1'b0; bus.req_addr = 0; bus.req_wdata = 0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_quiet("reset");
        @(posedge clk); #1;
        preload = 0;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_before_edge", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        chk("ready_after_reset", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        mon_en = 1;

        issue(0, 2'b10, 0, 32'h10, 0, 1);
        issue(1, 2'b00, 0, 32'h11, 32'hAB, 1);
        issue(0, 2'b10, 0, 32'h10, 0, 1);
        issue(0, 2'b00, 1, 32'h11, 0, 1);
        issue(0, 2'b00, 0, 32'h11, 0, 1);
        issue(0, 2'b01, 0, 32'h10, 0, 1);
        issue(0, 2'b01, 0, 32'h13, 0, 1);
        issue(1, 2'b10, 0, 32'h12, 32'h1234_5678, 1);
        issue(1, 2'b00, 0, 32'h21, 32'hCD, 0);
        issue(0, 2'b10, 0, 32'h20, 0, 1);

        // reset lands in cycle 2 of a byte store, while the read is pending
        mon_en = 0;
        rdy_en = 1;
        cs0 = cs_total; rs0 = rsp_total;
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b00;
        bus.req_addr = 32'h25; bus.req_wdata = 32'h5A;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk_quiet("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready_low", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        chk("midrst_ready_high", 32'(bus.req_ready), 32'd1);
        repeat (8) @(posedge clk);
        #1;
        chk("midrst_cs_count", 32'(cs_total - cs0), 32'd1);
        chk("midrst_rsp_count", 32'(rsp_total - rs0), 32'd0);
        mon_en = 1;
        issue(0, 2'b10, 0, 32'h24, 0, 1);

        for (int n = 0; n < 300; n++) begin
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)),
                  $urandom, $urandom_range(0, 15) != 0);
        end
        for (int i = 0; i < 64; i++) issue(0, 2'b10, 0, 32'(i * 4), 0, 1);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/limn2600_mem_ctrl.md
Name: limn2600_mem_ctrl

Overview:
CPU-side memory access controller sitting directly upstream of the limn2600 SRAM block. Accepts byte/halfword/word load and store requests from the core and converts them into single-cycle word-wide SRAM chip-select pulses, then waits on the SRAM ready flag. Sub-word stores are done as read-modify-write. Sub-word loads are lane-extracted and zero- or sign-extended. Also detects misalignment and bus timeout.

Parameters:
DATA_WIDTH, 32, SRAM word width; only 32 is supported.
TIMEOUT, 16, max cycles waited for mem_rdy after a mem_cs pulse before reporting an error (>=2).

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  controller idle, request accepted when req_valid&&req_ready at posedge
req_we  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
req_signed  in  1  loads only: 1=sign-extend sub-word result
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
rsp_valid  out  1  one-cycle response pulse
rsp_err  out  1  qualified by rsp_valid: misaligned/illegal size or timeout
rsp_rdata  out  32  load result, qualified by rsp_valid; 0 for stores and errors
mem_cs  out  1  SRAM chip select, one-cycle pulse per access
mem_we  out  1  SRAM write enable, valid with mem_cs
mem_addr  out  32  {req_addr[31:2],2'b00}
mem_wdata  out  32  SRAM write word
mem_rdy  in  1  SRAM ready, one cycle after mem_cs
mem_rdata  in  32  SRAM read word, valid with mem_rdy

Behaviour:
- All outputs registered. Reset: state IDLE, req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_cs=0, mem_we=0, mem_addr=0, mem_wdata=0, timeout counter=0. req_ready rises on the first posedge with rst low.
- rst high at any time, including mid read-modify-write, abandons the access. No further mem_cs is issued and no response is produced.
- Byte lanes are little-endian: lane n = bits [8n+7:8n], selected by addr[1:0]. A halfword uses lane pair addr[1]*2.
- Misaligned means: size=11, half with addr[0]=1, or word with addr[1:0]!=0. On a misaligned request: no mem_cs; rsp_valid=rsp_err=1 in the cycle after acceptance.
- States: IDLE, RD, RD_WAIT, WR, WR_WAIT, DONE.
- IDLE: req_ready=1. On accept, latch the request and drop req_ready.
  - Load, or sub-word store → RD.
  - Word store → WR.
  - Misaligned → DONE with error.
- RD: mem_cs=1, mem_we=0 for exactly one cycle → RD_WAIT.
- RD_WAIT, on mem_rdy=1:
  - Load → DONE, with the extracted and extended data.
  - Sub-word store → WR, with mem_wdata = mem_rdata with the target lane(s) replaced by req_wdata.
- WR: mem_cs=1, mem_we=1, mem_wdata valid for one cycle → WR_WAIT.
- WR_WAIT, on mem_rdy=1 → DONE.
- DONE: rsp_valid=1 for one cycle → IDLE. req_ready is 0 in DONE.
- Timeout: the counter clears on each mem_cs and increments each cycle spent in a *_WAIT state. If it reaches TIMEOUT with mem_rdy still 0 → DONE with rsp_err=1, rsp_rdata=0. For a read-modify-write that times out on its read, the write is not issued.
- mem_rdy outside a *_WAIT state is ignored.
- Latency, counting the accept cycle as 0:
  - Word load: mem_cs in cycle 1, rsp_valid in cycle 3.
  - Word store: rsp_valid in cycle 3.
  - Sub-word store: mem_cs in cycles 1 and 3, rsp_valid in cycle 5.
  - Next accept possible in the cycle after DONE.

Test Plan:
- SRAM preloaded with ram[i]=i. Word load at 0x00000010 → mem_cs in cycle 1 with mem_we=0, mem_addr=0x00000010; rsp_valid in cycle 3 with rsp_rdata=0x00000004, rsp_err=0.
- Byte store 0xAB at 0x00000011 → read at cycle 1, write at cycle 3 with mem_wdata=0x0000AB04; rsp_valid in cycle 5. A following word load at 0x10 returns 0x0000AB04.
- After the above, signed byte load at 0x00000011 → 0xFFFFFFAB. Unsigned → 0x000000AB. Unsigned halfword load at 0x00000010 → 0x0000AB04.
- Halfword load at 0x00000013, and word store at 0x00000012 → no mem_cs ever; rsp_valid with rsp_err=1 in cycle 1; rsp_rdata=0.
- Bench SRAM model holds mem_rdy=0, TIMEOUT=16, byte store → exactly one mem_cs (read, no write); rsp_err=1 16 cycles after the read's WAIT entry; req_ready returns next cycle.
- rst asserted in cycle 2 of a sub-word store → no write pulse, no rsp_valid, all outputs 0; req_ready=1 one cycle after rst drops; a new word load then completes normally.
